mu0_bus_timer: RTL

//  Memory-mapped countdown timer; responder on the MU0 data bus (Addr/Wr/write data/read data).

---
 rtl/mu0_bus_timer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mu0_bus_timer.sv
// Memory-mapped prescaled countdown timer that answers on the MU0 data bus beside MU0_Memory.
// Optional auto-reload mode is compiled in when MU0_TIMER_AUTORELOAD_EN is defined.
module mu0_bus_timer #(
  parameter logic [11:0]  ADDR_BASE = 12'hFF0,  // word address of CTRL, must be 4-aligned
  parameter int unsigned  PRESCALE  = 10        // Clk cycles per tick, >= 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Addr,
  input  logic [15:0] Wdata,
  input  logic        Wr,
  output logic [15:0] Rdata,
  output logic        Sel,
  output logic        Irq
);

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 16;
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PSW-1:0] PS_LAST  = PSW'(PRESCALE - 1);
  localparam logic [1:0]     OFS_CTRL = 2'd0;
  localparam logic [1:0]     OFS_LOAD = 2'd1;
  localparam logic [1:0]     OFS_CNT  = 2'd2;
  localparam logic [1:0]     OFS_STAT = 2'd3;

  logic           en, en_n;
  logic           auto_q;
  logic           irq_en, irq_en_n;
  logic [DW-1:0]  load_q, load_n;
  logic [DW-1:0]  count_q, count_n;
  logic           expired, expired_n;
  logic [PSW-1:0] presc, presc_n;

  logic wr_sel, wr_ctrl, wr_load, wr_count, wr_status;
  logic tick;

  // Address decode and bus write strobes
  assign Sel       = (Addr[AW-1:2] == ADDR_BASE[AW-1:2]);
  assign wr_sel    = Wr & Sel;
  assign wr_ctrl   = wr_sel & (Addr[1:0] == OFS_CTRL);
  assign wr_load   = wr_sel & (Addr[1:0] == OFS_LOAD);
  assign wr_count  = wr_sel & (Addr[1:0] == OFS_CNT);
  assign wr_status = wr_sel & (Addr[1:0] == OFS_STAT);

  assign tick = en & (presc == PS_LAST);

`ifdef MU0_TIMER_AUTORELOAD_EN
  logic auto_n;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) auto_q <= 1'b0;
    else       auto_q <= auto_n;
  end

  always_comb begin
    auto_n = auto_q;
    if (wr_ctrl) auto_n = Wdata[1];
  end
`else
  assign auto_q = 1'b0;
`endif

  // Next-state: tick effects first, bus writes override, expiry set beats status clear
  always_comb begin
    en_n      = en;
    irq_en_n  = irq_en;
    load_n    = load_q;
    count_n   = count_q;
    expired_n = expired;
    presc_n   = presc;

    if (wr_status && Wdata[0]) expired_n = 1'b0;

    // A simultaneous COUNT write discards the whole tick, expiry included
    if (tick && !wr_count) begin
      if (count_q > DW'(1)) begin
        count_n = count_q - DW'(1);
      end else begin
        expired_n = 1'b1;
        if (auto_q) begin
          count_n = load_q;
        end else begin
          count_n = '0;
          en_n    = 1'b0;
        end
      end
    end

    if (wr_count) count_n = Wdata;
    if (wr_load)  load_n  = Wdata;
    if (wr_ctrl) begin
      en_n     = Wdata[0];
      irq_en_n = Wdata[2];
    end

    if (!en_n || tick || (wr_ctrl && Wdata[0] && !en)) presc_n = '0;
    else                                                presc_n = presc + PSW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      expired <= 1'b0;
      presc   <= '0;
    end else begin
      en      <= en_n;
      irq_en  <= irq_en_n;
      load_q  <= load_n;
      count_q <= count_n;
      expired <= expired_n;
      presc   <= presc_n;
    end
  end

  // Zero wait-state read mux
  always_comb begin
    Rdata = '0;
    if (Sel) begin
      case (Addr[1:0])
        OFS_CTRL: Rdata = {13'b0, irq_en, auto_q, en};
        OFS_LOAD: Rdata = load_q;
        OFS_CNT:  Rdata = count_q;
        OFS_STAT: Rdata = {15'b0, expired};
        default:  Rdata = '0;
      endcase
    end
  end

  assign Irq = expired & irq_en;

endmodule
